// File: rtl/compress_pkg.sv
// Shared constants, FSM state type and legal-depth check for the compress/pack datapath.
package compress_pkg;

  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int D_MAX   = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic d_is_legal(input logic [3:0] d);
    logic ok;
    case (d)
      4'd1, 4'd4, 4'd5, 4'd10, 4'd11: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/compress_pack_ctrl_compress.sv
// Combinational coefficient compressor: round(2^d * x / q) mod 2^d.
module compress_pack_ctrl_compress
  import compress_pkg::*;
(
  input  logic [12:0]      coeff,
  input  logic [3:0]       d,
  output logic [D_MAX-1:0] comp
);

  logic [24:0] scaled_s;
  logic [24:0] quot_s;
  logic [24:0] mask_s;

  // q is odd, so adding (q-1)/2 before the floor division rounds half-up without ties
  always_comb begin
    scaled_s = ({12'd0, coeff} << d) + 25'((KYBER_Q - 1) / 2);
    quot_s   = scaled_s / 25'(KYBER_Q);
    mask_s   = (25'd1 << d) - 25'd1;
    comp     = D_MAX'(quot_s & mask_s);
  end

endmodule

// File: rtl/compress_pack_ctrl.sv
// Polynomial compress-and-pack controller: packs d-bit compressed coefficients LSB-first into W_WORD words.
// Optional build macro COMPRESS_RANGE_CHECK_EN adds a sticky out-of-range flag on accepted coefficients.
module compress_pack_ctrl
  import compress_pkg::*;
#(
  parameter int N_COEFF = KYBER_N,
  parameter int W_WORD  = 32
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [3:0]        i_d,
  input  logic [12:0]       i_coeff,
  input  logic              i_coeff_valid,
  output logic              o_coeff_ready,
  output logic [W_WORD-1:0] o_word,
  output logic              o_word_valid,
  input  logic              i_word_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_range_err
);

  localparam int ACC_W  = W_WORD + D_MAX;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int CNT_W  = $clog2(N_COEFF + 1);

  state_t             state_r;
  state_t             state_s;
  logic [3:0]         d_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [FILL_W-1:0]  fill_r;
  logic [ACC_W-1:0]   acc_r;
  logic [W_WORD-1:0]  word_r;
  logic               word_valid_r;
  logic               busy_r;
  logic               done_r;
  logic               err_r;
  logic [D_MAX-1:0]   comp_s;
  logic               start_ok_s;
  logic               start_bad_s;
  logic               coeff_ready_s;
  logic               accept_s;
  logic               shift_s;
  logic               last_s;

  compress_pack_ctrl_compress u_compress (
    .coeff (i_coeff),
    .d     (d_r),
    .comp  (comp_s)
  );

  // Handshake qualifiers; accept needs fill<W_WORD and shift needs fill>=W_WORD, so they never coincide
  always_comb begin
    start_ok_s    = (state_r == ST_IDLE) && i_start && d_is_legal(i_d);
    start_bad_s   = (state_r == ST_IDLE) && i_start && !d_is_legal(i_d);
    coeff_ready_s = (state_r == ST_RUN) && (fill_r < FILL_W'(W_WORD)) && (cnt_r < CNT_W'(N_COEFF));
    accept_s      = coeff_ready_s && i_coeff_valid;
    shift_s       = (state_r == ST_RUN) && (fill_r >= FILL_W'(W_WORD)) && (!word_valid_r || i_word_ready);
    last_s        = (state_r == ST_RUN) && (cnt_r == CNT_W'(N_COEFF)) && (fill_r == FILL_W'(0))
                    && (!word_valid_r || i_word_ready);
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: if (start_ok_s) state_s = ST_RUN;  else state_s = ST_IDLE;
      ST_RUN:  if (last_s)     state_s = ST_DONE; else state_s = ST_RUN;
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, accumulator and output word registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r      <= ST_IDLE;
      d_r          <= 4'd0;
      cnt_r        <= '0;
      fill_r       <= '0;
      acc_r        <= '0;
      word_r       <= '0;
      word_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
      err_r   <= start_bad_s;
      if (start_ok_s) begin
        d_r    <= i_d;
        cnt_r  <= '0;
        fill_r <= '0;
        acc_r  <= '0;
      end else if (accept_s) begin
        acc_r  <= acc_r | (ACC_W'(comp_s) << fill_r);
        fill_r <= fill_r + FILL_W'(d_r);
        cnt_r  <= cnt_r + CNT_W'(1);
      end else if (shift_s) begin
        acc_r  <= acc_r >> W_WORD;
        fill_r <= fill_r - FILL_W'(W_WORD);
      end
      // a stalled word is never overwritten because shift_s requires a free slot
      if (shift_s) begin
        word_r       <= acc_r[W_WORD-1:0];
        word_valid_r <= 1'b1;
      end else if (i_word_ready) begin
        word_valid_r <= 1'b0;
      end
    end
  end

`ifdef COMPRESS_RANGE_CHECK_EN
  logic range_err_r;

  // Sticky out-of-range flag, cleared by a legal start; data is compressed regardless
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      range_err_r <= 1'b0;
    end else if (start_ok_s) begin
      range_err_r <= 1'b0;
    end else if (accept_s && (i_coeff >= 13'(KYBER_Q))) begin
      range_err_r <= 1'b1;
    end
  end

  assign o_range_err = range_err_r;
`else
  assign o_range_err = 1'b0;
`endif

  assign o_coeff_ready = coeff_ready_s;
  assign o_word        = word_r;
  assign o_word_valid  = word_valid_r;
  assign o_busy        = busy_r;
  assign o_done        = done_r;
  assign o_err         = err_r;

endmodule

// File: doc/compress_pack_ctrl.md
COMPRESS_PACK_CTRL -- requirements
Module: compress_pack_ctrl

Interface
REQ-001 SHALL have parameter N_COEFF, default 256, coefficients per polynomial.
REQ-002 SHALL have parameter W_WORD, default 32, packed output word width.
REQ-003 SHALL have ports:
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_start  in  1  start pulse, sampled in IDLE only
- i_d  in  4  compression depth, sampled with i_start; legal values {1,4,5,10,11}
- i_coeff  in  13  input coefficient
- i_coeff_valid  in  1  coefficient valid
- o_coeff_ready  out  1  coefficient ready
- o_word  out  W_WORD  packed compressed bits
- o_word_valid  out  1  word valid
- i_word_ready  in  1  word ready
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse at end of polynomial
- o_err  out  1  one-cycle pulse on illegal i_d at start
- o_range_err  out  1  sticky range flag (see Configuration)

Function
REQ-004 SHALL implement states IDLE, RUN, DONE.
REQ-005 IDLE->RUN on i_start with legal i_d; i_d is latched into d_q; the coefficient counter, accumulator and fill count are cleared.
REQ-006 IDLE + i_start with illegal i_d SHALL pulse o_err for one cycle and stay in IDLE.
REQ-007 i_start outside IDLE SHALL be ignored.
REQ-008 Compression SHALL be combinational on i_coeff using d_q: round(2^d*x/3329) mod 2^d, via the compress sub-module.
REQ-009 o_coeff_ready = (state==RUN) && (fill<W_WORD) && (coeff_cnt<N_COEFF).
REQ-010 On accept (valid&&ready), the d_q-bit result SHALL be ORed into a 43-bit accumulator at bit position fill; fill += d_q; coeff_cnt += 1. Visible next cycle.
REQ-011 Packing SHALL be LSB-first: coefficient 0 occupies o_word[d-1:0] of the first word.
REQ-012 When fill>=W_WORD and the output slot is free (!o_word_valid || i_word_ready), o_word SHALL load acc[31:0], acc shifts right 32, fill -= 32, and o_word_valid is set the next cycle.
REQ-013 Accept and shift SHALL be mutually exclusive in a cycle, which follows from REQ-009.
REQ-014 o_word and o_word_valid SHALL hold stable while o_word_valid && !i_word_ready.
REQ-015 With no backpressure, first-word latency SHALL be 1 cycle after the accept that brings fill>=32.
REQ-016 N_COEFF*d is a multiple of 32 for every legal d, so there SHALL be no partial final word. Word counts: d=1:8, 4:32, 5:40, 10:80, 11:88.
REQ-017 RUN->DONE when coeff_cnt==N_COEFF, fill==0, and the last word is handshaken. DONE pulses o_done, then ->IDLE next cycle.

Reset
REQ-018 Asserting i_rstn low at any time, including mid-polynomial, SHALL force state=IDLE and clear all registers. All outputs SHALL be 0, including o_word=0. A partially packed polynomial is discarded.

Configuration
REQ-019 With COMPRESS_RANGE_CHECK_EN defined, any accepted i_coeff >= 3329 SHALL set o_range_err. The flag is sticky until the next legal start or reset. The data is still compressed.
REQ-020 Without COMPRESS_RANGE_CHECK_EN, o_range_err SHALL be tied 0 and no comparator is built.

Structure
REQ-021 The shared package compress_pkg SHALL hold: KYBER_Q=3329, KYBER_N=256, the legal-d list or check function, and the state enum.
REQ-022 SHALL instantiate exactly one sub-module, the team's combinational compress unit. Control, accumulator and output register SHALL stay in compress_pack_ctrl.

Verification
REQ-023 d=1, 256 coeffs of 1665, no backpressure -> exactly 8 words of 0xFFFFFFFF, then o_done one cycle later.
REQ-024 d=11, coeff0=3328, coeff1=0, rest 0 -> word0[10:0]=0x7FF and word0[21:11]=0; 88 words total.
REQ-025 d=4, coeffs cycling 0,208,416,... with i_word_ready toggling 1-of-3 cycles -> o_word stable while stalled, 32 words, contents match the reference model.
REQ-026 i_start with i_d=7 -> o_err pulse, o_busy stays 0, no words emitted.
REQ-027 d=10, drop i_rstn after 100 coeffs -> all outputs 0 next edge; a restart with d=5 produces exactly 40 correct words.
REQ-028 COMPRESS_RANGE_CHECK_EN defined, one coeff of 4000 -> o_range_err=1 until the next i_start; undefined -> o_range_err stays 0.
